// File: rtl/bk_adder_pipe_chk.sv
// Pipelined Brent-Kung adder with a ripple-carry reference carried alongside.
// Each output beat is compared against the reference; mismatch and beat counts are kept.
module bk_adder_pipe_chk #(
  parameter int N      = 32,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     ina,
  input  logic [N-1:0]     inb,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     outbk,
  output logic             coutbk,
  output logic [N-1:0]     outrc,
  output logic             coutrc,
  output logic             beat_err,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int L     = $clog2(N);
  localparam int NL    = 2*L - 1;
  localparam int BASE  = NL / STAGES;
  localparam int EXTRA = NL % STAGES;

  function automatic int f_lo(input int s);
    return s*BASE + ((s < EXTRA) ? s : EXTRA);
  endfunction

  // Level j < L is up-sweep span 2^j; later levels walk the down-sweep back to span 1.
  function automatic logic [2*N-1:0] f_lvl(input logic [2*N-1:0] gp,
                                           input int j);
    logic [N-1:0] g, p, go, po;
    int           sp;
    logic         hit;
    g  = gp[2*N-1:N];
    p  = gp[N-1:0];
    go = g;
    po = p;
    sp = (j < L) ? (1 << j) : (1 << (2*L - 2 - j));
    for (int i = 0; i < N; i++) begin
      if (j < L) hit = (((i + 1) % (2*sp)) == 0);
      else       hit = (((i + 1) % (2*sp)) == sp) && (i > sp);
      if (hit) begin
        go[i] = g[i] | (p[i] & g[i-sp]);
        po[i] = p[i] & p[i-sp];
      end
    end
    return {go, po};
  endfunction

  logic [N-1:0]      w_gi [STAGES];
  logic [N-1:0]      w_pi [STAGES];
  logic [N-1:0]      w_xi [STAGES];
  logic              w_ci [STAGES];
  logic [N-1:0]      w_g0;
  logic [N:0]        w_rc;
  logic              w_rcc;
  logic [N:0]        w_bk;
  logic [STAGES-1:0] w_adv;
  logic              w_oxfer;

  logic [STAGES-1:0] r_v;
  logic [N:0]        r_ref [STAGES];
  logic              r_mis;
  logic [CNT_W-1:0]  r_err;
  logic [CNT_W-1:0]  r_txn;

  // Carry-in is folded into bit 0 generate so the tree yields true carries.
  always_comb begin
    w_g0    = ina & inb;
    w_g0[0] = (ina[0] & inb[0]) | ((ina[0] ^ inb[0]) & cin);
  end

  assign w_gi[0] = w_g0;
  assign w_pi[0] = ina ^ inb;
  assign w_xi[0] = ina ^ inb;
  assign w_ci[0] = cin;

  always_comb begin
    w_rc  = '0;
    w_rcc = cin;
    for (int i = 0; i < N; i++) begin
      w_rc[i] = ina[i] ^ inb[i] ^ w_rcc;
      w_rcc   = (ina[i] & inb[i]) | (w_rcc & (ina[i] ^ inb[i]));
    end
    w_rc[N] = w_rcc;
  end

  // A stage moves when it or any stage downstream of it has a hole.
  always_comb begin
    w_adv = '0;
    for (int s = 0; s < STAGES; s++) begin
      w_adv[s] = out_ready;
      for (int t = s; t < STAGES; t++)
        if (!r_v[t]) w_adv[s] = 1'b1;
    end
  end

  assign in_ready = w_adv[0];
  assign w_oxfer  = r_v[STAGES-1] & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int s = 0; s < STAGES; s++) r_ref[s] <= '0;
    end else begin
      if (w_adv[0]) begin
        r_v[0]   <= in_valid;
        r_ref[0] <= w_rc;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (w_adv[s]) begin
          r_v[s]   <= r_v[s-1];
          r_ref[s] <= r_ref[s-1];
        end
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = f_lo(s);
    localparam int HI = f_lo(s + 1);
    logic [2*N-1:0] w_gp;

    always_comb begin
      w_gp = {w_gi[s], w_pi[s]};
      for (int j = LO; j < HI; j++) w_gp = f_lvl(w_gp, j);
    end

    if (s < STAGES - 1) begin : g_mid
      logic [N-1:0] r_g, r_p, r_x;
      logic         r_c;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_g <= '0;
          r_p <= '0;
          r_x <= '0;
          r_c <= 1'b0;
        end else if (w_adv[s]) begin
          r_g <= w_gp[2*N-1:N];
          r_p <= w_gp[N-1:0];
          r_x <= w_xi[s];
          r_c <= w_ci[s];
        end
      end
      assign w_gi[s+1] = r_g;
      assign w_pi[s+1] = r_p;
      assign w_xi[s+1] = r_x;
      assign w_ci[s+1] = r_c;
    end else begin : g_last
      logic [N:0] r_sum;
      logic       w_unused_p;
      assign w_unused_p = ^w_gp[N-1:0];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sum <= '0;
        else if (w_adv[s])
          r_sum <= {w_gp[2*N-1],
                    w_xi[s] ^ {w_gp[2*N-2:N], w_ci[s]}};
      end
      assign w_bk = r_sum;
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign outbk     = w_bk[N-1:0];
  assign coutbk    = w_bk[N];
  assign outrc     = r_ref[STAGES-1][N-1:0];
  assign coutrc    = r_ref[STAGES-1][N];
  assign beat_err  = (outbk != outrc) | (coutbk != coutrc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mis <= 1'b0;
      r_err <= '0;
      r_txn <= '0;
    end else if (clr) begin
      r_mis <= 1'b0;
      r_err <= '0;
      r_txn <= '0;
    end else if (w_oxfer) begin
      if (r_txn != '1) r_txn <= r_txn + CNT_W'(1);
      if (beat_err) begin
        r_mis <= 1'b1;
        if (r_err != '1) r_err <= r_err + CNT_W'(1);
      end
    end
  end

  assign mismatch = r_mis;
  assign err_cnt  = r_err;
  assign txn_cnt  = r_txn;

endmodule

// File: tb/tb_bk_adder_pipe_chk.sv
// Directed bench for bk_adder_pipe_chk: latency, carry chain, streaming,
// backpressure, forced mismatch, clear and asynchronous reset.
module tb_bk_adder_pipe_chk;
  localparam int N      = 32;
  localparam int STAGES = 3;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     ina = '0;
  logic [N-1:0]     inb = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     outbk;
  logic             coutbk;
  logic [N-1:0]     outrc;
  logic             coutrc;
  logic             beat_err;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] txn_cnt;

  int n_run  = 0;
  int n_fail = 0;

  logic [N:0]   q[$];
  logic [N:0]   exp_v;
  logic [N-1:0] a, b;
  logic         c;
  logic         acc_in, acc_out, saw;
  int           sent, got, first, last;

  logic [N-1:0] sa [6];
  logic [N-1:0] sb [6];
  logic         sc [6];
  logic [N:0]   sexp [6];

  bk_adder_pipe_chk #(.N(N), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .outbk(outbk), .coutbk(coutbk),
    .outrc(outrc), .coutrc(coutrc),
    .beat_err(beat_err), .mismatch(mismatch),
    .err_cnt(err_cnt), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int maxc);
    for (int i = 0; i < maxc && !out_valid; i++) step();
    chk("wait_out_valid", 64'(out_valid), 64'd1);
  endtask

  initial begin
    sa = '{32'h0000_0001, 32'h0000_0010, 32'h7FFF_FFFF,
           32'hFFFF_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    sb = '{32'h0000_0001, 32'h0000_0020, 32'h0000_0001,
           32'h0001_0000, 32'h8765_4321, 32'hFFFF_FFFF};
    sc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    sexp = '{33'h0_0000_0002, 33'h0_0000_0030, 33'h0_8000_0000,
             33'h1_0000_0000, 33'h0_9999_9999, 33'h1_FFFF_FFFF};

    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_mismatch",  64'(mismatch),  64'd0);
    chk("rst_err_cnt",   64'(err_cnt),   64'd0);
    chk("rst_txn_cnt",   64'(txn_cnt),   64'd0);
    chk("rst_outbk",     64'({coutbk, outbk}), 64'd0);
    chk("rst_outrc",     64'({coutrc, outrc}), 64'd0);
    chk("rst_beat_err",  64'(beat_err),  64'd0);

    rst = 1'b0;
    out_ready = 1'b1;

    // 5 + 3 + 1 = 9, three cycles of latency
    ina = 32'h5; inb = 32'h3; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_e0_ov", 64'(out_valid), 64'd0);
    step();
    chk("lat_e1_ov", 64'(out_valid), 64'd0);
    step();
    chk("lat_e2_ov", 64'(out_valid), 64'd1);
    chk("t1_outbk",  64'({coutbk, outbk}), 64'h0_0000_0009);
    chk("t1_outrc",  64'({coutrc, outrc}), 64'h0_0000_0009);
    chk("t1_beat_err", 64'(beat_err), 64'd0);
    step();
    chk("t1_txn", 64'(txn_cnt), 64'd1);
    chk("t1_ov_drop", 64'(out_valid), 64'd0);

    // full carry chain
    ina = 32'hFFFF_FFFF; inb = 32'h0; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(10);
    chk("t2_outbk",  64'(outbk),  64'd0);
    chk("t2_coutbk", 64'(coutbk), 64'd1);
    chk("t2_outrc",  64'(outrc),  64'd0);
    chk("t2_coutrc", 64'(coutrc), 64'd1);
    chk("t2_beat_err", 64'(beat_err), 64'd0);
    step();
    chk("t2_txn", 64'(txn_cnt), 64'd2);

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr1_txn", 64'(txn_cnt), 64'd0);

    // 100 back-to-back random beats
    sent = 0; got = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
      if (sent < 100) begin
        a = $urandom;
        b = $urandom;
        c = 1'($urandom_range(0, 1));
        ina = a; inb = b; cin = c; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc_in = in_valid && in_ready;
      if (acc_in) q.push_back({1'b0, a} + {1'b0, b} + {{N{1'b0}}, c});
      if (out_valid) begin
        exp_v = (q.size() > 0) ? q.pop_front() : '1;
        chk("rnd_bk", 64'({coutbk, outbk}), 64'(exp_v));
        chk("rnd_rc", 64'({coutrc, outrc}), 64'(exp_v));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(posedge clk);
      #1;
      if (acc_in) sent++;
    end
    in_valid = 1'b0;
    chk("rnd_count", 64'(got), 64'd100);
    chk("rnd_span", 64'(last - first), 64'd99);
    chk("rnd_txn", 64'(txn_cnt), 64'd100);
    chk("rnd_err", 64'(err_cnt), 64'd0);
    chk("rnd_mis", 64'(mismatch), 64'd0);

    // backpressure: out_ready low for 5 cycles while streaming 6 beats
    sent = 0; got = 0;
    for (int cy = 0; cy < 40 && got < 6; cy++) begin
      out_ready = (cy >= 5);
      in_valid = (sent < 6);
      if (sent < 6) begin
        ina = sa[sent]; inb = sb[sent]; cin = sc[sent];
      end
      #1;
      if (cy == 3) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_hold3", 64'({coutbk, outbk}), 64'(sexp[0]));
      end
      if (cy == 4) begin
        chk("stall_ov", 64'(out_valid), 64'd1);
        chk("stall_hold4", 64'({coutbk, outbk}), 64'(sexp[0]));
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        chk("stall_beat", 64'({coutbk, outbk}), 64'(sexp[got]));
        got++;
      end
      @(posedge clk);
      #1;
      if (acc_in) sent++;
    end
    in_valid = 1'b0;
    chk("stall_got", 64'(got), 64'd6);
    chk("stall_txn", 64'(txn_cnt), 64'd106);

    // clr in the same cycle as an output transfer
    out_ready = 1'b0;
    ina = 32'h1; inb = 32'h2; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(10);
    out_ready = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clrx_txn", 64'(txn_cnt), 64'd0);
    chk("clrx_ov", 64'(out_valid), 64'd0);

    // forced mismatch: 1 + 2 = 3, bit 0 pulled low
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(10);
    force dut.w_bk = 33'h0_0000_0002;
    #1;
    chk("f_outbk", 64'(outbk), 64'd2);
    chk("f_beat_err", 64'(beat_err), 64'd1);
    out_ready = 1'b1;
    step();
    release dut.w_bk;
    chk("f_err", 64'(err_cnt), 64'd1);
    chk("f_mis", 64'(mismatch), 64'd1);
    chk("f_txn", 64'(txn_cnt), 64'd1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("c_err", 64'(err_cnt), 64'd0);
    chk("c_txn", 64'(txn_cnt), 64'd0);
    chk("c_mis", 64'(mismatch), 64'd0);

    // reset with two beats in flight
    ina = 32'h5; inb = 32'h6; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(10);
    step();
    chk("pre_txn", 64'(txn_cnt), 64'd1);
    in_valid = 1'b1;
    step();
    ina = 32'h7;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("ar_ov", 64'(out_valid), 64'd0);
    chk("ar_ir", 64'(in_ready), 64'd1);
    chk("ar_txn", 64'(txn_cnt), 64'd0);
    step();
    step();
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      saw = saw | out_valid;
    end
    chk("ar_stale", 64'(saw), 64'd0);
    chk("ar_txn2", 64'(txn_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/bk_adder_pipe_chk.md
Name: bk_adder_pipe_chk

Overview:
- Parametrised, pipelined Brent-Kung prefix adder with valid/ready handshake on input and output.
- Carries a ripple-carry reference sum through the same pipeline and compares the two results at the output stage.
- Maintains a sticky mismatch flag, an error counter and a transaction counter.
- Sits between operand sources and the adder verification/monitor logic, replacing the unpipelined fixed-width dual adder.

Parameters:
- N, 32, operand width in bits; power of two, 8..64.
- STAGES, 3, pipeline register stages (latency in cycles); 1..(2*log2(N)-1).
- CNT_W, 16, width of err_cnt and txn_cnt.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous clear of mismatch, err_cnt and txn_cnt; pipeline contents unaffected.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  pipeline can accept a beat this cycle.
- ina  in  N  operand A.
- inb  in  N  operand B.
- cin  in  1  carry in.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- outbk  out  N  Brent-Kung sum.
- coutbk  out  1  Brent-Kung carry out.
- outrc  out  N  ripple-carry reference sum.
- coutrc  out  1  ripple-carry reference carry out.
- beat_err  out  1  current output beat mismatches; qualified by out_valid.
- mismatch  out  1  sticky: set on any delivered mismatching beat.
- err_cnt  out  CNT_W  count of delivered mismatching beats; saturates.
- txn_cnt  out  CNT_W  count of delivered beats; saturates.

Behaviour:
- Reset (asynchronous, rst=1):
  - All stage valid bits are 0, so out_valid=0 and in_ready=1 after reset.
  - mismatch=0, err_cnt=0, txn_cnt=0.
  - Data registers are 0, so outbk, outrc, coutbk, coutrc and beat_err read 0.
- Prefix tree:
  - Per-bit generate/propagate, then 2*log2(N)-1 levels: up-sweep, then down-sweep, then sum XOR.
  - Levels are split into STAGES groups as evenly as possible, with any extra level in the earliest groups.
  - A register bank follows each group; the last bank drives the outputs.
- Reference path: the ripple-carry sum of the same operands is computed combinationally at input and registered alongside every stage.
- Width rules:
  - {coutbk,outbk} = ina + inb + cin, computed modulo 2^(N+1).
  - {coutrc,outrc} has the same definition.
- Handshake:
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
  - Stage k advances when it is empty, or when stage k+1 advances or is empty. The last stage advances when out_ready=1 or it is empty.
  - in_ready = stage 0 empty, or stage 0 advancing. It is combinational from out_ready through the stall chain.
  - Latency is exactly STAGES cycles from input transfer to out_valid when there is no backpressure.
  - Throughput is 1 beat/cycle.
  - A stalled stage holds its data and valid bit stable; no beat is dropped or duplicated.
  - out_valid may not drop until the beat has transferred.
- Compare:
  - beat_err = (outbk != outrc) | (coutbk != coutrc), evaluated on registered last-stage data.
- Counters and flag update only on an output transfer:
  - txn_cnt increments by 1.
  - If beat_err, err_cnt increments by 1 and mismatch is set.
  - Both counters saturate at 2^CNT_W-1.
- clr:
  - clr and a transfer in the same cycle: clr wins; the counters read 0 and mismatch reads 0 on the next cycle, and that beat is not counted.
- Reset mid-operation: all in-flight beats are discarded immediately; no output transfer occurs in that cycle.
- Idle: with in_valid=0, the pipeline drains, and out_valid falls after the last beat transfers.

Test Plan:
- N=32, STAGES=3, reset released, ina=0x0000_0005, inb=0x0000_0003, cin=1 in one beat with out_ready=1 -> out_valid high exactly 3 cycles later; outbk=0x0000_0009, coutbk=0, beat_err=0; txn_cnt=1.
- ina=0xFFFF_FFFF, inb=0x0000_0000, cin=1 (full carry chain) -> outbk=0x0000_0000, coutbk=1, outrc=0, coutrc=1, beat_err=0.
- 100 back-to-back random beats with out_ready held 1 -> one result per cycle in input order; both sums match a bench model; txn_cnt=100, err_cnt=0, mismatch=0.
- Stream 6 beats while out_ready is held 0 for 5 cycles -> in_ready falls once all 3 stages are full; outputs stay stable during the stall; on release all 6 beats arrive in order with none lost.
- Force an outbk bit 0 via bench override on one beat, then assert clr on a later idle cycle -> that beat shows beat_err=1, then err_cnt=1 and mismatch=1; after clr, err_cnt=0, txn_cnt=0, mismatch=0.
- Assert rst while 2 beats are in flight -> out_valid=0 and in_ready=1 immediately (no clock edge needed); counters are 0; no stale beat appears after rst deasserts.
